// File: rtl/filter_mode_controller.sv
// filter_mode_controller: owns the filter mode and smoothed pitch that feed
// the per-pixel filter stage. A debounced key advances a shadow mode, raw
// pitch samples are smoothed by an exponential moving average, and both are
// committed only on a start-of-frame pulse. This keeps every frame rendered
// with one consistent set of filter settings.
//
// Optional build macro FILTER_AUTO_CYCLE_EN adds a frame counter that
// injects one press every AUTO_FRAMES frames.
module filter_mode_controller #(
  parameter int NUM_FILTERS     = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PITCH_SHIFT     = 2,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key,
  input  logic        pitch_valid,
  input  logic [29:0] pitch_in,
  input  logic        sof,
  output logic [2:0]  filter_selection,
  output logic [29:0] pitch_output,
  output logic        mode_changed
);

  localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      SEL_LAST = 3'(NUM_FILTERS - 1);

  localparam logic [0:0] SYNCED  = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [DB_W-1:0] db_cnt;
  logic            key_press;
  logic            auto_press;
  logic            press_evt;
  logic [2:0]      shadow;
  logic [29:0]     acc;
  logic            acc_loaded;
  logic [0:0]      state;

  // Debounce: count consecutive high cycles, saturate, clear on release
  always_ff @(posedge clk) begin
    if (reset)
      db_cnt <= '0;
    else if (!key)
      db_cnt <= '0;
    else if (db_cnt != DB_MAX)
      db_cnt <= db_cnt + 1'b1;
  end

  // One press per held period: the cycle the count reaches its limit
  assign key_press = key && (db_cnt == DB_LAST);

`ifdef FILTER_AUTO_CYCLE_EN
  localparam int              FC_W    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt;

  // Frame counter: wraps every AUTO_FRAMES start-of-frame pulses
  always_ff @(posedge clk) begin
    if (reset)
      frame_cnt <= '0;
    else if (sof)
      frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
  end

  assign auto_press = sof && (frame_cnt == FC_LAST);
`else
  logic [31:0] unused_auto_frames;
  assign unused_auto_frames = AUTO_FRAMES;
  assign auto_press         = 1'b0;
`endif

  // Key and auto presses in the same cycle collapse into a single advance
  assign press_evt = key_press | auto_press;

  // Shadow mode: wraps back to 0 after the last filter
  always_ff @(posedge clk) begin
    if (reset)
      shadow <= '0;
    else if (press_evt)
      shadow <= (shadow == SEL_LAST) ? 3'd0 : shadow + 3'd1;
  end

  // EMA step in 31-bit signed; the true result lies between acc and the
  // sample, so keeping the low 30 bits of the sum is exact.
  logic signed [30:0] ema_diff;
  logic signed [30:0] ema_step;
  logic        [30:0] ema_sum;
  logic               unused_ema_msb;

  // Next accumulator value for a loaded accumulator
  always_comb begin
    ema_diff = $signed({1'b0, pitch_in}) - $signed({1'b0, acc});
    ema_step = ema_diff >>> PITCH_SHIFT;
    ema_sum  = {1'b0, acc} + $unsigned(ema_step);
  end

  assign unused_ema_msb = ema_sum[30];

  // Accumulator: first sample loads directly, later samples are smoothed
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      acc_loaded <= 1'b0;
    end else if (pitch_valid) begin
      acc        <= acc_loaded ? ema_sum[29:0] : pitch_in;
      acc_loaded <= 1'b1;
    end
  end

  // Commit FSM: outputs move only on sof, from values registered before it
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= SYNCED;
      filter_selection <= '0;
      pitch_output     <= '0;
      mode_changed     <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      if (sof)
        pitch_output <= acc;
      if (state == SYNCED) begin
        if (press_evt)
          state <= PENDING;
      end else begin
        if (sof) begin
          filter_selection <= shadow;
          mode_changed     <= (shadow != filter_selection);
          // A press landing on the commit sof waits for the next frame
          state            <= press_evt ? PENDING : SYNCED;
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_mode_controller.sv
// Scoreboard bench for filter_mode_controller. Each sof pushes the outputs
// expected in the following cycle; a monitor pops them one cycle after sof
// and otherwise checks that outputs hold with mode_changed low.
module tb_filter_mode_controller;

  typedef struct {
    logic [2:0]  sel;
    logic [29:0] pitch;
    logic        mc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key = 1'b0;
  logic        pitch_valid = 1'b0;
  logic [29:0] pitch_in = '0;
  logic        sof = 1'b0;
  logic [2:0]  filter_selection;
  logic [29:0] pitch_output;
  logic        mode_changed;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic sof_q = 1'b0;
  logic mon_on = 1'b0;
  logic [2:0]  held_sel = '0;
  logic [29:0] held_pitch = '0;

  filter_mode_controller #(
    .NUM_FILTERS(4), .DEBOUNCE_CYCLES(4), .PITCH_SHIFT(2), .AUTO_FRAMES(3)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .pitch_valid(pitch_valid),
    .pitch_in(pitch_in), .sof(sof), .filter_selection(filter_selection),
    .pitch_output(pitch_output), .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sof_q <= sof && !reset;

  // Monitor: compare against scoreboard after each sof, else check hold
  always @(negedge clk) begin
    if (reset) begin
      held_sel   = '0;
      held_pitch = '0;
    end else if (mon_on) begin
      if (sof_q) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: output cycle with no expected entry");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (filter_selection !== e.sel || pitch_output !== e.pitch || mode_changed !== e.mc) begin
            errors++;
            $display("FAIL commit: got sel=%0d pitch=%0d mc=%0b, expected sel=%0d pitch=%0d mc=%0b",
                     filter_selection, pitch_output, mode_changed, e.sel, e.pitch, e.mc);
          end
          held_sel   = e.sel;
          held_pitch = e.pitch;
        end
      end else begin
        checks++;
        if (filter_selection !== held_sel || pitch_output !== held_pitch || mode_changed !== 1'b0) begin
          errors++;
          $display("FAIL hold: got sel=%0d pitch=%0d mc=%0b, expected sel=%0d pitch=%0d mc=0 at %0t",
                   filter_selection, pitch_output, mode_changed, held_sel, held_pitch, $time);
        end
      end
    end
  end

  task automatic step(input logic k, input logic pv, input logic [29:0] pin, input logic s);
    key = k; pitch_valid = pv; pitch_in = pin; sof = s;
    @(posedge clk); #1;
    key = 1'b0; pitch_valid = 1'b0; pitch_in = '0; sof = 1'b0;
  endtask

  task automatic expect_out(input logic [2:0] s, input logic [29:0] p, input logic m);
    exp_t e;
    e.sel = s; e.pitch = p; e.mc = m;
    sb.push_back(e);
  endtask

  task automatic do_sof(input logic [2:0] s, input logic [29:0] p, input logic m);
    expect_out(s, p, m);
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic press();
    repeat (4) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    do_reset(2);
    checks++;
    if (filter_selection !== 3'd0 || pitch_output !== 30'd0 || mode_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset: got sel=%0d pitch=%0d mc=%0b, expected 0 0 0",
               filter_selection, pitch_output, mode_changed);
    end
    mon_on = 1'b1;
    do_sof(0, 0, 0);
    step(0, 0, 0, 0);

`ifdef FILTER_AUTO_CYCLE_EN
    // Auto advance every 3 frames
    do_sof(0, 0, 0);
    do_sof(0, 0, 0);
    do_sof(1, 0, 1);
    do_sof(1, 0, 0);
    do_sof(1, 0, 0);
    do_sof(2, 0, 1);
    do_sof(2, 0, 0);
    // Key press coinciding with the auto press advances by one only
    repeat (3) step(1, 0, 0, 0);
    expect_out(2, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    do_sof(3, 0, 1);
    step(0, 0, 0, 0);
`else
    // Short high period: no press
    repeat (3) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    do_sof(0, 0, 0);
    // Long hold: exactly one press
    repeat (10) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    do_sof(1, 0, 1);
    step(0, 0, 0, 0);
    // Sequential presses with wrap
    press(); do_sof(2, 0, 1);
    press(); do_sof(3, 0, 1);
    press(); do_sof(0, 0, 1);
    // Two presses in one frame
    press(); press(); do_sof(2, 0, 1);
    // Full cycle of presses: no change, no pulse
    press(); press(); press(); press(); do_sof(2, 0, 0);

    // EMA: first load, smoothing, truncation toward negative infinity
    step(0, 1, 30'd40, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    do_sof(2, 40, 0);
    step(0, 1, 30'd8, 0);
    do_sof(2, 32, 0);
    step(0, 1, 30'd33, 0);
    do_sof(2, 32, 0);
    step(0, 1, 30'd0, 0);
    step(0, 1, 30'd25, 0);
    step(0, 1, 30'd21, 0);
    do_sof(2, 23, 0);

    // Press coinciding with sof commits at the following sof
    repeat (3) step(1, 0, 0, 0);
    expect_out(2, 23, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    do_sof(3, 23, 1);
    // Sample coinciding with sof: old acc committed
    expect_out(3, 23, 0);
    step(0, 1, 30'd100, 1);
    do_sof(3, 42, 0);

    // Reset while pending discards the change and the accumulator
    press();
    do_reset(1);
    step(0, 0, 0, 0);
    do_sof(0, 0, 0);
    step(0, 1, 30'd50, 0);
    do_sof(0, 50, 0);
    step(0, 0, 0, 0);
`endif

    repeat (2) step(0, 0, 0, 0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_mode_controller.md
Name: filter_mode_controller

Overview:
- Sequences the pixel filter datapath.
- Owns the filter_selection and pitch_output values that drive it.
- Debounces a user key to cycle filter modes and smooths raw pitch samples with an exponential moving average.
- Commits both values only on a start-of-frame pulse, so a VGA frame never shows mixed filter settings. Sits between the key/audio-pitch front end and the per-pixel filter stage.

Parameters:
- NUM_FILTERS, 4: number of selectable modes; selection cycles 0..NUM_FILTERS-1 (max 8).
- DEBOUNCE_CYCLES, 1000000: consecutive high cycles of key required to register one press (min 2).
- PITCH_SHIFT, 2: EMA weight, alpha = 1/2^PITCH_SHIFT.
- AUTO_FRAMES, 120: frames between automatic advances (used only with AUTO_CYCLE_EN).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- key  input  1  key level, already synchronised to clk, active-high = pressed.
- pitch_valid  input  1  one-cycle strobe qualifying pitch_in.
- pitch_in  input  30  raw unsigned pitch sample.
- sof  input  1  one-cycle start-of-frame pulse from VGA timing.
- filter_selection  output  3  committed filter mode to the filter datapath.
- pitch_output  output  30  committed smoothed pitch to the filter datapath.
- mode_changed  output  1  one-cycle pulse when a new filter_selection is committed.

Behaviour:
- Reset (synchronous, clk edge with reset=1): filter_selection=0, pitch_output=0, mode_changed=0, shadow selection=0, EMA accumulator=0, acc_loaded=0, debounce counter=0, state=SYNCED. Reset overrides all other inputs in the same cycle.
- Debounce:
  - Counter increments each cycle key=1 and saturates at DEBOUNCE_CYCLES; it clears to 0 when key=0.
  - A press event fires in the single cycle the counter transitions DEBOUNCE_CYCLES-1 -> DEBOUNCE_CYCLES. This gives exactly one press per held period; a high period shorter than DEBOUNCE_CYCLES gives no press.
- Shadow selection: on a press event, shadow <= (shadow == NUM_FILTERS-1) ? 0 : shadow+1, at the next edge.
- Pitch EMA:
  - On pitch_valid with acc_loaded=0: acc <= pitch_in, acc_loaded <= 1.
  - On pitch_valid with acc_loaded=1: acc <= acc + ((pitch_in - acc) >>> PITCH_SHIFT). Compute in 31-bit signed; the arithmetic shift truncates toward negative infinity. The result always lies between old acc and pitch_in, so no overflow is possible.
- State machine:
  - SYNCED: shadow == filter_selection. Press event -> PENDING.
  - PENDING: shadow != filter_selection (or a press occurred). On sof: filter_selection <= shadow; mode_changed=1 next cycle only if the value differs; -> SYNCED.
- pitch_output <= acc on every sof, in any state.
- Commit semantics: sof samples shadow and acc as registered at the start of that cycle.
  - A press event or pitch_valid coinciding with sof takes effect at the following sof.
  - Presses totalling a multiple of NUM_FILTERS between two sofs commit no change and give no mode_changed.
- Latency: sof at cycle N -> outputs updated at the edge ending cycle N, visible in cycle N+1. mode_changed is high exactly in cycle N+1.
- Between sofs: filter_selection and pitch_output are held constant.
- Reset mid-PENDING: pending change is discarded, no mode_changed pulse.

Optional Feature:
- Macro: FILTER_AUTO_CYCLE_EN.
- Defined: a frame counter increments on each sof. When it reaches AUTO_FRAMES-1 and sof occurs, it wraps to 0 and generates an internal press event in that cycle, which commits at the next sof.
  - A key press in the same cycle as an auto press advances shadow by one only; the two are not additive.
  - Frame counter resets to 0.
- Undefined: no frame counter; selection changes only via key.

Test Plan (DEBOUNCE_CYCLES=4, PITCH_SHIFT=2, NUM_FILTERS=4):
1. Assert reset 2 cycles -> filter_selection=0, pitch_output=0, mode_changed=0; sof after reset -> outputs stay 0, no mode_changed.
2. key high 3 cycles then low, then sof -> selection stays 0. Next, key high 10 cycles, then sof -> selection=1, mode_changed high exactly one cycle.
3. Four separate press+sof sequences -> selection 1,2,3,0. Then two presses before one sof -> selection jumps 0->2 with a single mode_changed pulse.
4. pitch_valid with pitch_in=40, no sof -> pitch_output stays 0. sof -> 40. pitch_valid with pitch_in=8 -> acc=32; sof -> 32. pitch_valid with pitch_in=33 -> acc=32 ((1>>>2)=0); sof -> 32.
5. Press event and sof in the same cycle -> selection unchanged at that sof, advances at the next sof. pitch_valid with sof in the same cycle -> old acc committed.
6. Press, then reset before sof -> selection 0, no mode_changed. With FILTER_AUTO_CYCLE_EN and AUTO_FRAMES=3 -> selection advances once every 3 sofs.
